// File: rtl/core_pipe_skid_reg_if.sv
// Handshake bundle for core_pipe_skid_reg: upstream offer, downstream entry and status.
// The master side drives the entry and flow control; the slave side is the skid register.
interface core_pipe_skid_reg_if #(
  parameter int unsigned CTRL_W = 10,
  parameter int unsigned DATA_W = 111
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occ;
  logic [15:0]       stall_cnt;

  modport master (
    output flush, in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data, occ, stall_cnt
  );

  modport slave (
    input  flush, in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data, occ, stall_cnt
  );
endinterface

// File: rtl/core_pipe_skid_reg.sv
// Two-entry pipeline register: a main register driving the outputs and one skid register,
// so in_ready is registered and no combinational path runs from input to output.
module core_pipe_skid_reg #(
  parameter int unsigned CTRL_W = 10,
  parameter int unsigned DATA_W = 111
) (
  input logic                 clk,
  input logic                 rst,
  core_pipe_skid_reg_if.slave pipe_io
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e            state_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [1:0]        occ_q;
  logic [CTRL_W-1:0] main_ctrl_q;
  logic [DATA_W-1:0] main_data_q;
  logic [CTRL_W-1:0] skid_ctrl_q;
  logic [DATA_W-1:0] skid_data_q;
  logic [15:0]       stall_cnt_q;

  logic accept;
  logic consume;

  assign accept  = pipe_io.in_valid & in_ready_q;
  assign consume = out_valid_q & pipe_io.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StEmpty;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occ_q       <= 2'd0;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      // Stall accounting ignores flush on purpose.
      if (out_valid_q && !pipe_io.out_ready && stall_cnt_q != 16'hFFFF) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end

      if (pipe_io.flush) begin
        state_q     <= StEmpty;
        in_ready_q  <= 1'b1;
        out_valid_q <= 1'b0;
        occ_q       <= 2'd0;
        main_ctrl_q <= '0;
      end else begin
        case (state_q)
          StEmpty: begin
            if (accept) begin
              state_q     <= StOne;
              out_valid_q <= 1'b1;
              occ_q       <= 2'd1;
              main_ctrl_q <= pipe_io.in_ctrl;
              main_data_q <= pipe_io.in_data;
            end
          end
          StOne: begin
            if (accept && consume) begin
              main_ctrl_q <= pipe_io.in_ctrl;
              main_data_q <= pipe_io.in_data;
            end else if (consume) begin
              // Clearing ctrl keeps out_ctrl zero while no entry is held.
              state_q     <= StEmpty;
              out_valid_q <= 1'b0;
              occ_q       <= 2'd0;
              main_ctrl_q <= '0;
            end else if (accept) begin
              state_q     <= StFull;
              in_ready_q  <= 1'b0;
              occ_q       <= 2'd2;
              skid_ctrl_q <= pipe_io.in_ctrl;
              skid_data_q <= pipe_io.in_data;
            end
          end
          StFull: begin
            if (consume) begin
              state_q     <= StOne;
              in_ready_q  <= 1'b1;
              occ_q       <= 2'd1;
              main_ctrl_q <= skid_ctrl_q;
              main_data_q <= skid_data_q;
            end
          end
          default: begin
            state_q     <= StEmpty;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            occ_q       <= 2'd0;
            main_ctrl_q <= '0;
          end
        endcase
      end
    end
  end

  assign pipe_io.in_ready  = in_ready_q;
  assign pipe_io.out_valid = out_valid_q;
  assign pipe_io.out_ctrl  = main_ctrl_q;
  assign pipe_io.out_data  = main_data_q;
  assign pipe_io.occ       = occ_q;
  assign pipe_io.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_core_pipe_skid_reg.sv
// Bench for core_pipe_skid_reg: directed scenarios plus random traffic, all checked every
// cycle against a two-slot FIFO model with saturating stall accounting.
module tb_core_pipe_skid_reg;
  localparam int unsigned CW = 10;
  localparam int unsigned DW = 111;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  core_pipe_skid_reg_if #(.CTRL_W(CW), .DATA_W(DW)) pif ();

  core_pipe_skid_reg #(.CTRL_W(CW), .DATA_W(DW)) dut (
    .clk    (clk),
    .rst    (rst),
    .pipe_io(pif)
  );

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          mq[$];
  logic [DW-1:0] m_data;
  int unsigned   m_stall;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Reference: a FIFO of at most two entries, updated from the inputs seen at the edge.
  task automatic model_edge();
    bit   acc;
    bit   con;
    ent_t e;
    if (rst) begin
      mq.delete();
      m_data  = '0;
      m_stall = 0;
      return;
    end
    if (mq.size() != 0 && !pif.out_ready && m_stall < 65535) m_stall++;
    if (pif.flush) begin
      mq.delete();
      return;
    end
    acc = pif.in_valid && (mq.size() < 2);
    con = (mq.size() != 0) && pif.out_ready;
    if (con) void'(mq.pop_front());
    if (acc) begin
      e.c = pif.in_ctrl;
      e.d = pif.in_data;
      mq.push_back(e);
    end
    if (mq.size() != 0) m_data = mq[0].d;
  endtask

  task automatic check_all(input string tag);
    logic [CW-1:0] ec;
    ec = (mq.size() != 0) ? mq[0].c : '0;
    chk({tag, ".out_valid"}, 128'(pif.out_valid), 128'(mq.size() != 0));
    chk({tag, ".out_ctrl"}, 128'(pif.out_ctrl), 128'(ec));
    chk({tag, ".out_data"}, 128'(pif.out_data), 128'(m_data));
    chk({tag, ".in_ready"}, 128'(pif.in_ready), 128'(mq.size() < 2));
    chk({tag, ".occ"}, 128'(pif.occ), 128'(mq.size()));
    chk({tag, ".stall_cnt"}, 128'(pif.stall_cnt), 128'(m_stall));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic rand_entry();
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    pif.in_data = t[DW-1:0];
    pif.in_ctrl = t[CW+40-1:40];
  endtask

  initial begin
    rst           = 1'b1;
    pif.flush     = 1'b0;
    pif.in_valid  = 1'b0;
    pif.in_ctrl   = '1;
    pif.in_data   = '1;
    pif.out_ready = 1'b0;
    m_data        = '0;
    m_stall       = 0;
    @(negedge clk);
    cycle("reset");
    chk("reset.in_ready_const", 128'(pif.in_ready), 128'(1));
    rst = 1'b0;

    // Single entry, 1-cycle latency
    pif.in_ctrl = 10'h3FF; pif.in_data = 111'd5; pif.in_valid = 1'b1; pif.out_ready = 1'b1;
    cycle("single_load");
    pif.in_valid = 1'b0;
    chk("single.out_valid", 128'(pif.out_valid), 128'(1));
    chk("single.out_ctrl", 128'(pif.out_ctrl), 128'(10'h3FF));
    chk("single.out_data", 128'(pif.out_data), 128'(5));
    cycle("single_drain");
    chk("single.gone_valid", 128'(pif.out_valid), 128'(0));
    chk("single.gone_ctrl", 128'(pif.out_ctrl), 128'(0));

    // Back-pressure A, B, C
    pif.out_ready = 1'b0; pif.in_valid = 1'b1;
    pif.in_ctrl = 10'h0A; pif.in_data = 111'hA;
    cycle("bp_a");
    pif.in_ctrl = 10'h0B; pif.in_data = 111'hB;
    cycle("bp_b");
    pif.in_ctrl = 10'h0C; pif.in_data = 111'hC;
    for (int i = 0; i < 3; i++) cycle("bp_hold");
    chk("bp.occ_full", 128'(pif.occ), 128'(2));
    chk("bp.in_ready_low", 128'(pif.in_ready), 128'(0));
    chk("bp.head_a", 128'(pif.out_data), 128'(111'hA));
    pif.out_ready = 1'b1;
    cycle("bp_drain1");
    chk("bp.head_b", 128'(pif.out_data), 128'(111'hB));
    cycle("bp_drain2");
    chk("bp.head_c", 128'(pif.out_data), 128'(111'hC));
    pif.in_valid = 1'b0;
    cycle("bp_drain3");
    chk("bp.empty", 128'(pif.out_valid), 128'(0));

    // Full-rate streaming
    pif.in_valid = 1'b1; pif.out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      rand_entry();
      cycle("stream");
      chk("stream.occ_one", 128'(pif.occ), 128'(1));
      chk("stream.in_ready_high", 128'(pif.in_ready), 128'(1));
    end
    pif.in_valid = 1'b0;
    cycle("stream_tail");

    // Flush at occ=2 while offering an entry
    pif.out_ready = 1'b0; pif.in_valid = 1'b1;
    rand_entry(); cycle("fl_fill1");
    rand_entry(); cycle("fl_fill2");
    pif.flush = 1'b1; pif.in_ctrl = 10'h155; pif.in_data = 111'h1234;
    cycle("flush");
    chk("flush.occ", 128'(pif.occ), 128'(0));
    chk("flush.out_ctrl", 128'(pif.out_ctrl), 128'(0));
    pif.flush = 1'b0; pif.in_valid = 1'b0; pif.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle("flush_after");

    // rst and flush together at occ=2
    pif.out_ready = 1'b0; pif.in_valid = 1'b1;
    rand_entry(); cycle("rf_fill1");
    rand_entry(); cycle("rf_fill2");
    rst = 1'b1; pif.flush = 1'b1;
    cycle("rst_flush");
    chk("rst_flush.out_data", 128'(pif.out_data), 128'(0));
    rst = 1'b0; pif.flush = 1'b0; pif.in_valid = 1'b0;
    cycle("rst_flush_after");

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      pif.in_valid  = ($urandom_range(0, 3) != 0);
      pif.out_ready = ($urandom_range(0, 2) != 0);
      pif.flush     = ($urandom_range(0, 63) == 0);
      rand_entry();
      cycle("random");
    end
    pif.flush = 1'b0;

    // Stall counter saturation, flush immunity, reset clear
    pif.in_valid = 1'b1; pif.out_ready = 1'b0; rand_entry();
    cycle("sat_load");
    pif.in_valid = 1'b0;
    for (int i = 0; i < 70000; i++) cycle("sat");
    chk("sat.max", 128'(pif.stall_cnt), 128'(16'hFFFF));
    pif.flush = 1'b1;
    cycle("sat_flush");
    chk("sat.after_flush", 128'(pif.stall_cnt), 128'(16'hFFFF));
    pif.flush = 1'b0; rst = 1'b1;
    cycle("sat_rst");
    chk("sat.after_rst", 128'(pif.stall_cnt), 128'(0));
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
